// File: rtl/spi_write.sv
// SPI write initiator: shifts an address word and then N FIFO data words out MSB first.
// spi_clk is gated off while the next data word is still on its way from the FIFO.
module spi_write #(
   parameter int REG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 new_command,
   input  logic [7:0]           num_regs_to_write,
   input  logic [REG_WIDTH-1:0] start_write_register_addr,
   input  logic [REG_WIDTH-1:0] fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   output logic                 serial_out,
   output logic                 spi_clk,
   output logic                 busy,
   output logic                 write_one_byte_complete,
   output logic                 write_complete
);
   localparam int BW = $clog2(REG_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(REG_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SEND_ADDRESS, SEND_DATA, STALL, COMPLETE} state_t;

   state_t                 state, state_nxt;
   logic                   prev_new_command;
   logic [REG_WIDTH-1:0]   shift_reg, shift_nxt;
   logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
   logic [8:0]             words_sent, words_sent_nxt;
   logic [8:0]             words_requested, words_requested_nxt;
   logic [7:0]             count, count_nxt;
   logic [REG_WIDTH-1:0]   hold_reg, hold_reg_nxt;
   logic                   hold_valid, hold_valid_nxt;
   logic                   rd_pending;
   logic                   fifo_rd_en_nxt;
   logic                   serial_out_nxt;
   logic                   spi_clk_en, spi_clk_en_nxt;
   logic                   busy_nxt;
   logic                   byte_done, byte_done_nxt;
   logic                   write_complete_nxt;
   logic                   cmd_rise;

   assign cmd_rise = new_command & ~prev_new_command;
   assign spi_clk  = rstn & spi_clk_en & ~clk;

   always_comb begin
      state_nxt           = state;
      shift_nxt           = shift_reg;
      bit_cnt_nxt         = bit_cnt;
      words_sent_nxt      = words_sent;
      words_requested_nxt = words_requested;
      count_nxt           = count;
      hold_reg_nxt        = hold_reg;
      hold_valid_nxt      = hold_valid;
      fifo_rd_en_nxt      = 1'b0;
      serial_out_nxt      = serial_out;
      spi_clk_en_nxt      = 1'b0;
      busy_nxt            = busy;
      byte_done_nxt       = 1'b0;
      write_complete_nxt  = 1'b0;

      // Prefetch: a capture can only happen while hold_valid is low, so it never
      // collides with the FSM consuming hold_reg below.
      if (rd_pending) begin
         hold_reg_nxt   = fifo_data;
         hold_valid_nxt = 1'b1;
      end
      if (busy && !hold_valid && !fifo_rd_en && !rd_pending && !fifo_empty &&
          (words_requested < {1'b0, count})) begin
         fifo_rd_en_nxt      = 1'b1;
         words_requested_nxt = words_requested + 9'd1;
      end

      case (state)
         IDLE: begin
            if (cmd_rise) begin
               count_nxt           = num_regs_to_write;
               shift_nxt           = start_write_register_addr;
               bit_cnt_nxt         = '0;
               words_sent_nxt      = '0;
               words_requested_nxt = '0;
               busy_nxt            = 1'b1;
               state_nxt           = (num_regs_to_write == 8'd0) ? COMPLETE : SEND_ADDRESS;
            end
         end
         SEND_ADDRESS, SEND_DATA: begin
            serial_out_nxt = shift_reg[REG_WIDTH-1];
            spi_clk_en_nxt = 1'b1;
            shift_nxt      = shift_reg << 1;
            bit_cnt_nxt    = bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
               bit_cnt_nxt   = '0;
               byte_done_nxt = (state == SEND_DATA);
               if (state == SEND_DATA && words_sent == {1'b0, count}) begin
                  state_nxt = COMPLETE;
               end else if (hold_valid) begin
                  shift_nxt      = hold_reg;
                  hold_valid_nxt = 1'b0;
                  words_sent_nxt = words_sent + 9'd1;
                  state_nxt      = SEND_DATA;
               end else begin
                  state_nxt = STALL;
               end
            end
         end
         STALL: begin
            if (hold_valid) begin
               shift_nxt      = hold_reg;
               hold_valid_nxt = 1'b0;
               words_sent_nxt = words_sent + 9'd1;
               bit_cnt_nxt    = '0;
               state_nxt      = SEND_DATA;
            end
         end
         COMPLETE: begin
            serial_out_nxt     = 1'b0;
            write_complete_nxt = 1'b1;
            busy_nxt           = 1'b0;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The byte-complete strobe lags the last data bit by one cycle so it fires
   // only after that bit has been clocked out on spi_clk.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state                   <= IDLE;
         prev_new_command        <= 1'b0;
         shift_reg               <= '0;
         bit_cnt                 <= '0;
         words_sent              <= '0;
         words_requested         <= '0;
         count                   <= '0;
         hold_reg                <= '0;
         hold_valid              <= 1'b0;
         rd_pending              <= 1'b0;
         fifo_rd_en              <= 1'b0;
         serial_out              <= 1'b0;
         spi_clk_en              <= 1'b0;
         busy                    <= 1'b0;
         byte_done               <= 1'b0;
         write_one_byte_complete <= 1'b0;
         write_complete          <= 1'b0;
      end else begin
         state                   <= state_nxt;
         prev_new_command        <= new_command;
         shift_reg               <= shift_nxt;
         bit_cnt                 <= bit_cnt_nxt;
         words_sent              <= words_sent_nxt;
         words_requested         <= words_requested_nxt;
         count                   <= count_nxt;
         hold_reg                <= hold_reg_nxt;
         hold_valid              <= hold_valid_nxt;
         rd_pending              <= fifo_rd_en;
         fifo_rd_en              <= fifo_rd_en_nxt;
         serial_out              <= serial_out_nxt;
         spi_clk_en              <= spi_clk_en_nxt;
         busy                    <= busy_nxt;
         byte_done               <= byte_done_nxt;
         write_one_byte_complete <= byte_done;
         write_complete          <= write_complete_nxt;
      end
   end

endmodule

// File: tb/tb_spi_write.sv
// Scoreboard bench for spi_write: expected MOSI words are queued at stimulus time and a
// forked monitor rebuilds words from rising spi_clk samples and compares them.
module tb_spi_write;
   logic       clk = 1'b0;
   logic       rstn;
   logic       new_command;
   logic [7:0] num_regs_to_write;
   logic [7:0] start_write_register_addr;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic       serial_out;
   logic       spi_clk;
   logic       busy;
   logic       write_one_byte_complete;
   logic       write_complete;

   spi_write #(.REG_WIDTH(8)) dut (
      .clk                       (clk),
      .rstn                      (rstn),
      .new_command               (new_command),
      .num_regs_to_write         (num_regs_to_write),
      .start_write_register_addr (start_write_register_addr),
      .fifo_data                 (fifo_data),
      .fifo_empty                (fifo_empty),
      .fifo_rd_en                (fifo_rd_en),
      .serial_out                (serial_out),
      .spi_clk                   (spi_clk),
      .busy                      (busy),
      .write_one_byte_complete   (write_one_byte_complete),
      .write_complete            (write_complete)
   );

   always #5 clk = ~clk;

   // Upstream FIFO model: data appears the cycle after a read strobe.
   logic [7:0] fifo_mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       flush = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (fifo_rd_en && rd_ptr != wr_ptr) begin
         fifo_data <= fifo_mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rst_count = 0;
   int spi_pulses = 0, rd_pulses = 0, byte_pulses = 0, wc_pulses = 0, busy_cycles = 0;
   int first_pulse_cycle = -1, last_pulse_cycle = -1, wc_cycle = -1, cmd_cycle = 0;
   logic [7:0] exp_q [$];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_fifo(input logic [7:0] d);
      fifo_mem[wr_ptr % 64] = d;
      wr_ptr++;
   endtask

   task automatic monitor();
      logic [7:0] acc = 8'h00;
      int nbits = 0;
      int seen_rst = 0;
      forever begin
         @(negedge clk); #1;
         cyc++;
         if (rst_count != seen_rst) begin
            seen_rst = rst_count;
            nbits = 0;
         end
         if (fifo_rd_en) rd_pulses++;
         if (write_one_byte_complete) byte_pulses++;
         if (busy) busy_cycles++;
         if (write_complete) begin
            wc_pulses++;
            wc_cycle = cyc;
         end
         if (spi_clk) begin
            spi_pulses++;
            if (first_pulse_cycle < 0) first_pulse_cycle = cyc;
            last_pulse_cycle = cyc;
            acc = {acc[6:0], serial_out};
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               if (exp_q.size() == 0) check_output("unexpected_word", {24'h0, acc}, 32'hFFFF_FFFF);
               else check_output("mosi_word", {24'h0, acc}, {24'h0, exp_q.pop_front()});
            end
         end
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] n);
      @(negedge clk); #2;
      start_write_register_addr = a;
      num_regs_to_write = n;
      new_command = 1'b1;
      cmd_cycle = cyc;
      first_pulse_cycle = -1;
   endtask

   task automatic release_command();
      @(negedge clk); #2;
      new_command = 1'b0;
   endtask

   task automatic wait_complete(input int base, input int budget, input string name);
      int n = 0;
      while (wc_pulses == base && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      check_output({name, "_done"}, {31'h0, wc_pulses > base}, 32'h1);
      repeat (2) @(negedge clk);
      #2;
   endtask

   int b_spi, b_rd, b_byte, b_wc, b_busy, stall_checks;

   task automatic snapshot();
      b_spi = spi_pulses; b_rd = rd_pulses; b_byte = byte_pulses;
      b_wc = wc_pulses; b_busy = busy_cycles;
   endtask

   initial begin
      rstn = 1'b0;
      new_command = 1'b0;
      num_regs_to_write = 8'h00;
      start_write_register_addr = 8'h00;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_busy", {31'h0, busy}, 0);
      check_output("rst_serial_out", {31'h0, serial_out}, 0);
      check_output("rst_spi_clk", {31'h0, spi_clk}, 0);
      check_output("rst_fifo_rd_en", {31'h0, fifo_rd_en}, 0);
      check_output("rst_write_complete", {31'h0, write_complete}, 0);
      rstn = 1'b1;

      // Single word: 0x3C then 0xA5
      snapshot();
      push_fifo(8'hA5);
      exp_q.push_back(8'h3C); exp_q.push_back(8'hA5);
      apply_stimulus(8'h3C, 8'd1);
      release_command();
      wait_complete(b_wc, 200, "t1");
      check_output("t1_spi_pulses", spi_pulses - b_spi, 16);
      check_output("t1_rd_pulses", rd_pulses - b_rd, 1);
      check_output("t1_byte_pulses", byte_pulses - b_byte, 1);
      check_output("t1_wc_pulses", wc_pulses - b_wc, 1);
      check_output("t1_wc_latency", wc_cycle - last_pulse_cycle, 1);
      check_output("t1_words_left", exp_q.size(), 0);

      // Three preloaded words must stream with no gap
      snapshot();
      push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
      exp_q.push_back(8'h01); exp_q.push_back(8'h11);
      exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      apply_stimulus(8'h01, 8'd3);
      release_command();
      wait_complete(b_wc, 200, "t2");
      check_output("t2_spi_pulses", spi_pulses - b_spi, 32);
      check_output("t2_contiguous", last_pulse_cycle - first_pulse_cycle + 1, 32);
      check_output("t2_rd_pulses", rd_pulses - b_rd, 3);
      check_output("t2_byte_pulses", byte_pulses - b_byte, 3);
      check_output("t2_words_left", exp_q.size(), 0);

      // Starved FIFO: second word arrives 20 cycles after the command
      snapshot();
      stall_checks = 0;
      push_fifo(8'hF0);
      exp_q.push_back(8'h42); exp_q.push_back(8'hF0); exp_q.push_back(8'h0F);
      apply_stimulus(8'h42, 8'd2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #2;
         new_command = 1'b0;
         if (byte_pulses - b_byte == 1 && stall_checks < 2) begin
            check_output("t3_stall_spi_clk", {31'h0, spi_clk}, 0);
            check_output("t3_stall_mosi", {31'h0, serial_out}, 0);
            stall_checks++;
         end
      end
      check_output("t3_stall_seen", stall_checks, 2);
      push_fifo(8'h0F);
      wait_complete(b_wc, 200, "t3");
      check_output("t3_spi_pulses", spi_pulses - b_spi, 24);
      check_output("t3_rd_pulses", rd_pulses - b_rd, 2);
      check_output("t3_words_left", exp_q.size(), 0);

      // Zero-length command
      snapshot();
      apply_stimulus(8'h99, 8'd0);
      release_command();
      wait_complete(b_wc, 50, "t4");
      check_output("t4_spi_pulses", spi_pulses - b_spi, 0);
      check_output("t4_rd_pulses", rd_pulses - b_rd, 0);
      check_output("t4_busy_cycles", busy_cycles - b_busy, 1);
      check_output("t4_wc_latency", wc_cycle - cmd_cycle, 2);

      // Held command plus toggles while busy: exactly one transfer
      snapshot();
      push_fifo(8'h3E);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h3E);
      apply_stimulus(8'h5A, 8'd1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         new_command = !(i == 5 || i == 9);
      end
      check_output("t5_wc_pulses", wc_pulses - b_wc, 1);
      check_output("t5_spi_pulses", spi_pulses - b_spi, 16);
      release_command();
      snapshot();
      push_fifo(8'hC7);
      exp_q.push_back(8'hA0); exp_q.push_back(8'hC7);
      apply_stimulus(8'hA0, 8'd1);
      release_command();
      wait_complete(b_wc, 200, "t5b");
      check_output("t5b_spi_pulses", spi_pulses - b_spi, 16);
      check_output("t5b_words_left", exp_q.size(), 0);

      // Reset pulse while bit 5 of the first data word is on the wire
      snapshot();
      push_fifo(8'h96); push_fifo(8'h69);
      exp_q.push_back(8'hC3);
      apply_stimulus(8'hC3, 8'd2);
      release_command();
      for (int i = 0; i < 100 && (spi_pulses - b_spi) < 11; i++) begin
         @(negedge clk); #2;
      end
      check_output("t6_reached_bit5", spi_pulses - b_spi, 11);
      rstn = 1'b0;
      rst_count++;
      #1;
      check_output("t6_spi_clk_drop", {31'h0, spi_clk}, 0);
      @(posedge clk); #1;
      check_output("t6_busy", {31'h0, busy}, 0);
      check_output("t6_serial_out", {31'h0, serial_out}, 0);
      check_output("t6_rd_en", {31'h0, fifo_rd_en}, 0);
      check_output("t6_byte_pulse", {31'h0, write_one_byte_complete}, 0);
      check_output("t6_write_complete", {31'h0, write_complete}, 0);
      rstn = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_output("t6_words_left", exp_q.size(), 0);
      exp_q.delete();
      snapshot();
      push_fifo(8'h81);
      exp_q.push_back(8'h7E); exp_q.push_back(8'h81);
      apply_stimulus(8'h7E, 8'd1);
      release_command();
      wait_complete(b_wc, 200, "t6b");
      check_output("t6b_spi_pulses", spi_pulses - b_spi, 16);
      check_output("t6b_words_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_write.md
Name: spi_write

Overview:
- SPI write initiator; the transmit-side counterpart to the board's SPI read engine.
- On a new_command rising edge it shifts out a REG_WIDTH-bit start register address, then num_regs_to_write data bytes pulled from an upstream FIFO, all MSB first.
- It drives serial_out and a gated spi_clk to an ASIC/peripheral register bank.
- When the FIFO runs dry mid-transfer, it stalls by gating spi_clk rather than sending garbage.

Parameters:
- REG_WIDTH, 8, width of the address word and of each data word (bits per spi_clk burst unit).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset, sampled on posedge clk
- new_command  in  1  level; a transfer starts on its 0->1 transition
- num_regs_to_write  in  8  data words to send; sampled at start
- start_write_register_addr  in  REG_WIDTH  address word; sampled at start
- fifo_data  in  REG_WIDTH  upstream FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  upstream FIFO empty flag
- fifo_rd_en  out  1  one-cycle read strobe to the FIFO
- serial_out  out  1  SPI MOSI
- spi_clk  out  1  gated SPI clock
- busy  out  1  high from start until write_complete
- write_one_byte_complete  out  1  one-cycle pulse per data word fully shifted
- write_complete  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset: on a posedge clk with rstn=0, the block:
  - goes to IDLE;
  - sets fifo_rd_en, serial_out, busy, write_one_byte_complete, write_complete and spi_clk_en to 0;
  - clears all counters and hold_valid;
  - sets prev_new_command to 0;
  - discards any FIFO read in flight.
- spi_clk is combinational: 0 when rstn=0 or spi_clk_en=0, else ~clk.
- serial_out changes only on posedge clk, so data is stable at each spi_clk rising edge (clk falling edge).
- Edge detection: prev_new_command is updated every cycle in all states. new_command held high through completion does not retrigger. Edges seen while busy are ignored.
- States are IDLE, SEND_ADDRESS, SEND_DATA, STALL, COMPLETE.
- IDLE:
  - On a rising edge with num_regs_to_write != 0: latch address and count, set busy=1, go to SEND_ADDRESS.
  - On a rising edge with num_regs_to_write == 0: go straight to COMPLETE. No spi_clk pulses, no FIFO reads.
- Prefetch (active while busy):
  - Single holding register hold_reg with hold_valid.
  - fifo_rd_en=1 when !hold_valid, no read outstanding, !fifo_empty, and words_requested < count.
  - On the next cycle fifo_data is captured into hold_reg and hold_valid=1.
  - Max one outstanding read.
  - Total fifo_rd_en pulses per transfer equal count exactly.
- SEND_ADDRESS: REG_WIDTH consecutive cycles, each driving the next address bit MSB first with spi_clk_en=1. After the last address bit:
  - if hold_valid: load the shift register from hold_reg (hold_valid=0) and drive data bit MSB in the next cycle (no gap);
  - otherwise go to STALL.
- SEND_DATA: one bit per cycle, MSB first. After bit 0 of a word, write_one_byte_complete pulses for one cycle, and:
  - if words_sent < count and hold_valid: load the next word seamlessly;
  - if words_sent < count and !hold_valid: go to STALL;
  - if words_sent == count: go to COMPLETE.
- STALL: spi_clk_en=0 and serial_out holds its last value. The block leaves when hold_valid=1, loads the word and resumes in SEND_DATA. There is no timeout.
- COMPLETE:
  - spi_clk_en=0 and serial_out=0;
  - write_complete=1 for one cycle, and busy=0 in the same cycle;
  - return to IDLE.
- Invariant: spi_clk pulse count = REG_WIDTH*(1+count), regardless of stalls.
- Counters: words_sent and words_requested are 9 bits wide, so count=255 cannot wrap. The bit counter is sized clog2(REG_WIDTH)+1.
- Reset mid-transfer: spi_clk drops to 0 immediately and all state clears on the next edge. The FIFO contents are not restored (upstream must flush).

Test Plan:
- addr=0x3C, N=1, FIFO holds {0xA5} -> fifo_rd_en 1 pulse; 16 spi_clk pulses; MOSI sampled on rising spi_clk = 0011_1100_1010_0101; write_one_byte_complete 1 pulse; write_complete 1 cycle after last bit.
- addr=0x01, N=3, FIFO preloaded {0x11,0x22,0x33} -> 32 contiguous spi_clk pulses with no gap, 3 rd_en pulses, 3 byte-complete pulses, MOSI = 0x01,0x11,0x22,0x33.
- N=2, FIFO holds only 0xF0, second word 0x0F pushed 20 cycles later -> spi_clk idle during STALL with MOSI held at 0; exactly 24 pulses total; second word shifts intact.
- N=0 rising edge -> no spi_clk, no rd_en, write_complete pulse 2 cycles after the edge; busy high exactly 1 cycle.
- new_command held high for 100 cycles, plus extra toggles while busy -> exactly one transfer; a new edge after write_complete starts a second transfer.
- rstn low for 1 cycle at bit 5 of data word 1 -> spi_clk 0 same cycle, all outputs 0 next edge, IDLE; a subsequent command completes normally.
